// File: rtl/adder2_seq_ctrl.sv
// adder2_seq_ctrl
// Digit-serial adder sequencer. Adds two WIDTH-bit operands plus a carry-in
// by streaming 2-bit digits, LSB first, through one external combinational
// 2-bit adder slice (adder2_b). The carry is chained through carry_r.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   A, B, Cin         operands, latched on the accepting edge
//   busy              high in RUN and DONE
//   done              one-cycle pulse; S/Cout valid
//   S, Cout           registered result, held until next completion or reset
//   slice_A/B/Cin     digit operands and chained carry to the slice (0 unless RUN)
//   slice_S/Cout      combinational return from the slice
module adder2_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [1:0]       slice_A,
  output logic [1:0]       slice_B,
  output logic             slice_Cin,
  input  logic [1:0]       slice_S,
  input  logic             slice_Cout
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry_r;

  logic             last;
  logic [WIDTH-1:0] a_sh, b_sh, sum_nx;

  assign last = (idx == IW'(N - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Current digit sits at the bottom of the shifted operand.
  assign a_sh = a_r >> {idx, 1'b0};
  assign b_sh = b_r >> {idx, 1'b0};

  // sum_r is cleared on accept and digits fill in order, so OR-ing the new
  // digit into its slot is the same as a part-select write.
  assign sum_nx = sum_r | (WIDTH'(slice_S) << {idx, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    slice_A   = 2'b00;
    slice_B   = 2'b00;
    slice_Cin = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        slice_A   = a_sh[1:0];
        slice_B   = b_sh[1:0];
        slice_Cin = carry_r;
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r     <= A;
          b_r     <= B;
          carry_r <= Cin;
          idx     <= '0;
          sum_r   <= '0;
        end
        RUN: begin
          sum_r   <= sum_nx;
          carry_r <= slice_Cout;
          idx     <= idx + 1'b1;
          if (last) begin
            S    <= sum_nx;
            Cout <= slice_Cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder2_seq_ctrl.sv
// Bench for adder2_seq_ctrl: three instances (WIDTH 8, 2, 16), each wired to
// a behavioural 2-bit slice adder. Results are compared against plain
// full-width arithmetic A+B+Cin.
module tb_adder2_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH = 8
  logic       s8_start, s8_cin, s8_busy, s8_done, s8_cout;
  logic [7:0] s8_a, s8_b, s8_s;
  logic [1:0] s8_sla, s8_slb, s8_sls;
  logic       s8_slcin, s8_slcout;
  assign {s8_slcout, s8_sls} = {1'b0, s8_sla} + {1'b0, s8_slb} + {2'b00, s8_slcin};

  adder2_seq_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8_start), .A(s8_a), .B(s8_b), .Cin(s8_cin),
    .busy(s8_busy), .done(s8_done), .S(s8_s), .Cout(s8_cout),
    .slice_A(s8_sla), .slice_B(s8_slb), .slice_Cin(s8_slcin),
    .slice_S(s8_sls), .slice_Cout(s8_slcout));

  // WIDTH = 2
  logic       s2_start, s2_cin, s2_busy, s2_done, s2_cout;
  logic [1:0] s2_a, s2_b, s2_s;
  logic [1:0] s2_sla, s2_slb, s2_sls;
  logic       s2_slcin, s2_slcout;
  assign {s2_slcout, s2_sls} = {1'b0, s2_sla} + {1'b0, s2_slb} + {2'b00, s2_slcin};

  adder2_seq_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(s2_start), .A(s2_a), .B(s2_b), .Cin(s2_cin),
    .busy(s2_busy), .done(s2_done), .S(s2_s), .Cout(s2_cout),
    .slice_A(s2_sla), .slice_B(s2_slb), .slice_Cin(s2_slcin),
    .slice_S(s2_sls), .slice_Cout(s2_slcout));

  // WIDTH = 16
  logic        s16_start, s16_cin, s16_busy, s16_done, s16_cout;
  logic [15:0] s16_a, s16_b, s16_s;
  logic [1:0]  s16_sla, s16_slb, s16_sls;
  logic        s16_slcin, s16_slcout;
  assign {s16_slcout, s16_sls} = {1'b0, s16_sla} + {1'b0, s16_slb} + {2'b00, s16_slcin};

  adder2_seq_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16_start), .A(s16_a), .B(s16_b), .Cin(s16_cin),
    .busy(s16_busy), .done(s16_done), .S(s16_s), .Cout(s16_cout),
    .slice_A(s16_sla), .slice_B(s16_slb), .slice_Cin(s16_slcin),
    .slice_S(s16_sls), .slice_Cout(s16_slcout));

  // Launch one WIDTH=8 operation and wait (bounded) for done.
  // lat = number of falling edges after the accepting edge until done seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] s, output logic co, output int lat);
    @(negedge clk);
    s8_start = 1'b1; s8_a = a; s8_b = b; s8_cin = c;
    @(negedge clk);
    s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom);
    lat = 1;
    while (!s8_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = s8_s; co = s8_cout;
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c,
                      output logic [1:0] s, output logic co, output int lat);
    @(negedge clk);
    s2_start = 1'b1; s2_a = a; s2_b = b; s2_cin = c;
    @(negedge clk);
    s2_start = 1'b0; s2_a = 2'($urandom); s2_b = 2'($urandom); s2_cin = 1'($urandom);
    lat = 1;
    while (!s2_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = s2_s; co = s2_cout;
  endtask

  task automatic test_reset();
    logic [7:0] s; logic co; int lat; int seen;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s8_s !== 8'h00 || s8_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b S=%h Cout=%b expected 0 0 00 0",
               s8_busy, s8_done, s8_s, s8_cout);
    end
    checks++;
    if (s8_sla !== 2'b00 || s8_slb !== 2'b00 || s8_slcin !== 1'b0) begin
      errors++;
      $display("FAIL reset_slice A=%b B=%b Cin=%b expected 0", s8_sla, s8_slb, s8_slcin);
    end
    // put a nonzero result in S so the abort visibly clears it
    run8(8'h0F, 8'h01, 1'b0, s, co, lat);
    checks++;
    if (s !== 8'h10 || co !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_sum S=%h Cout=%b expected 10 0", s, co);
    end
    // abort mid-RUN: accept at t0, rst sampled at t2
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'hAA; s8_b = 8'h55; s8_cin = 1'b0;
    @(negedge clk);
    s8_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s8_s !== 8'h00 || s8_cout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset busy=%b done=%b S=%h Cout=%b expected 0 0 00 0",
               s8_busy, s8_done, s8_s, s8_cout);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (s8_done || s8_busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL no_done_after_abort active_cycles=%0d expected 0", seen);
    end
    run8(8'h12, 8'h34, 1'b0, s, co, lat);
    checks++;
    if (s !== 8'h46 || co !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL after_reset_op S=%h Cout=%b lat=%0d expected 46 0 5", s, co, lat);
    end
  endtask

  task automatic test_ripple();
    logic [3:0] exp_cin;
    exp_cin = 4'b1110;  // digit k carry-in, digit 0 in bit 0
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'hFF; s8_b = 8'h01; s8_cin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s8_start = 1'b0;
      checks++;
      if (s8_slcin !== exp_cin[k] || s8_sla !== 2'b11 || s8_slb !== ((k == 0) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL ripple_digit%0d slice_Cin=%b A=%b B=%b expected Cin %b A 11",
                 k, s8_slcin, s8_sla, s8_slb, exp_cin[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (s8_done !== 1'b1 || s8_s !== 8'h00 || s8_cout !== 1'b1) begin
      errors++;
      $display("FAIL ripple_result done=%b S=%h Cout=%b expected 1 00 1", s8_done, s8_s, s8_cout);
    end
  endtask

  task automatic test_cin_only();
    logic [7:0] s; logic co; int lat;
    run8(8'h00, 8'h00, 1'b1, s, co, lat);
    checks++;
    if (s !== 8'h01 || co !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL cin_zero S=%h Cout=%b lat=%0d expected 01 0 5", s, co, lat);
    end
    run8(8'hFF, 8'hFF, 1'b1, s, co, lat);
    checks++;
    if (s !== 8'hFF || co !== 1'b1 || lat != 5) begin
      errors++;
      $display("FAIL cin_ones S=%h Cout=%b lat=%0d expected FF 1 5", s, co, lat);
    end
  endtask

  task automatic test_exhaustive_w2();
    logic [1:0] s; logic co; int lat; int ref_sum;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          run2(2'(a), 2'(b), 1'(c), s, co, lat);
          ref_sum = a + b + c;
          checks++;
          if ({co, s} !== 3'(ref_sum) || lat != 2) begin
            errors++;
            $display("FAIL w2_sweep a=%0d b=%0d c=%0d got=%0d lat=%0d expected %0d lat 2",
                     a, b, c, {co, s}, lat, ref_sum);
          end
        end
  endtask

  task automatic test_handshake();
    int t; int first; int second;
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'h3C; s8_b = 8'h5A; s8_cin = 1'b0;
    @(negedge clk);  // RUN digit 0
    s8_start = 1'b0;
    @(negedge clk);  // RUN digit 1: pulse start with other operands
    s8_start = 1'b1; s8_a = 8'hFF; s8_b = 8'hFF; s8_cin = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    @(negedge clk);
    @(negedge clk);  // DONE
    checks++;
    if (s8_done !== 1'b1 || s8_s !== 8'h96 || s8_cout !== 1'b0) begin
      errors++;
      $display("FAIL hs_ignore_run done=%b S=%h Cout=%b expected 1 96 0", s8_done, s8_s, s8_cout);
    end
    checks++;
    if (s8_sla !== 2'b00 || s8_slb !== 2'b00 || s8_slcin !== 1'b0) begin
      errors++;
      $display("FAIL hs_slice_done A=%b B=%b Cin=%b expected 0", s8_sla, s8_slb, s8_slcin);
    end
    s8_start = 1'b1;  // sampled in DONE: must be ignored
    @(negedge clk);
    s8_start = 1'b0;
    @(negedge clk);
    checks++;
    if (s8_busy !== 1'b0 || s8_done !== 1'b0) begin
      errors++;
      $display("FAIL hs_ignore_done busy=%b done=%b expected 0 0", s8_busy, s8_done);
    end
    // continuous start: accepts every N+2 = 6 cycles
    s8_start = 1'b1; s8_a = 8'h01; s8_b = 8'h02; s8_cin = 1'b0;
    first = -1; second = -1;
    for (t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (s8_done) begin
        if (first < 0) first = t;
        else if (second < 0) second = t;
      end
    end
    s8_start = 1'b0;
    checks++;
    if (first != 5 || second - first != 6 || s8_s !== 8'h03) begin
      errors++;
      $display("FAIL hs_back_to_back first=%0d spacing=%0d S=%h expected 5 6 03",
               first, second - first, s8_s);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random_w16();
    logic [15:0] a, b, prev_s; logic c, prev_co; logic [16:0] ref_sum; int lat;
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      ref_sum = {1'b0, a} + {1'b0, b} + {16'h0, c};
      @(negedge clk);
      prev_s = s16_s; prev_co = s16_cout;
      s16_start = 1'b1; s16_a = a; s16_b = b; s16_cin = c;
      @(negedge clk);
      s16_start = 1'b0; s16_a = 16'($urandom); s16_b = 16'($urandom);
      lat = 1;
      while (!s16_done && lat < 20) begin
        checks++;
        if (s16_s !== prev_s || s16_cout !== prev_co) begin
          errors++;
          $display("FAIL w16_stable n=%0d S=%h Cout=%b expected %h %b", n, s16_s, s16_cout, prev_s, prev_co);
        end
        @(negedge clk);
        lat++;
      end
      checks++;
      if ({s16_cout, s16_s} !== ref_sum || lat != 9) begin
        errors++;
        $display("FAIL w16_random n=%0d a=%h b=%h c=%b got=%h lat=%0d expected %h lat 9",
                 n, a, b, c, {s16_cout, s16_s}, lat, ref_sum);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0;
    s2_start = 1'b0; s2_a = '0; s2_b = '0; s2_cin = 1'b0;
    s16_start = 1'b0; s16_a = '0; s16_b = '0; s16_cin = 1'b0;
    test_reset();
    test_ripple();
    test_cin_only();
    test_exhaustive_w2();
    test_handshake();
    test_random_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder2_seq_ctrl.md
# adder2_seq_ctrl

Digit-serial sequencer that adds two WIDTH-bit operands with a single external 2-bit adder slice (`adder2_b`), one 2-bit digit per clock, LSB digit first. The carry is chained through an internal register, and the full sum and carry-out are presented with a start/busy/done handshake. It sits between a requester and one shared `adder2_b` instance, and owns all of that slice's inputs.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; must be even and ≥ 2; N = WIDTH/2 digits.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  operand A; sampled on the accepting edge.
- B  in  WIDTH  operand B; sampled on the accepting edge.
- Cin  in  1  carry-in; sampled on the accepting edge.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; S and Cout are valid.
- S  out  WIDTH  registered sum; holds its value until the next completion or reset.
- Cout  out  1  registered carry-out; holds like S.
- slice_A  out  2  digit of A driven to `adder2_b`.A.
- slice_B  out  2  digit of B driven to `adder2_b`.B.
- slice_Cin  out  1  chained carry driven to `adder2_b`.Cin.
- slice_S  in  2  `adder2_b`.S; combinational return.
- slice_Cout  in  1  `adder2_b`.Cout; combinational return.

## Operation
- States: IDLE, RUN, DONE. All state is registered. The slice is combinational, so each digit result is captured in the same cycle it is driven.
- IDLE, start=1 at an edge:
  - latch A→a_r, B→b_r, Cin→carry_r;
  - clear idx=0 and sum_r=0;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, combinational outputs:
  - slice_A = a_r[2*idx+1:2*idx];
  - slice_B = b_r[2*idx+1:2*idx];
  - slice_Cin = carry_r.
- RUN, each edge:
  - sum_r[2*idx+1:2*idx] ← slice_S;
  - carry_r ← slice_Cout;
  - idx ← idx+1.
- RUN, on the edge where idx = N-1:
  - S ← final sum (sum_r with the top digit = slice_S);
  - Cout ← slice_Cout;
  - go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- start is ignored in RUN and DONE; there is no queuing. A, B and Cin are don't-care after the accepting edge.
- slice_A, slice_B and slice_Cin are 0 in IDLE and DONE.
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1). The carry wraps correctly across digits; the result matches the full-width sum exactly.
- idx is ceil(log2(N)) bits wide, minimum 1. For N=1, RUN lasts one cycle.
- Reset (rst=1 at any edge, including mid-RUN or in DONE) has priority over everything:
  - state=IDLE;
  - idx, a_r, b_r, carry_r, sum_r, S, Cout, busy and done all 0;
  - any operation in progress is aborted and its result is discarded.

## Timing
- Reset values: busy=0, done=0, S=0, Cout=0, slice_A=0, slice_B=0, slice_Cin=0.
- Accepting edge t0, with start=1 in IDLE. busy goes to 1 after t0.
- RUN occupies the cycles after t0 … t(N-1). The digit k result is captured at edge t(k+1), for k = 0…N-1.
- S, Cout and done update at edge tN. done is high for the cycle after tN. busy falls after t(N+1).
- Latency: N+1 cycles from the accepting edge to done. Minimum start-to-start spacing is N+2 cycles. A start held high continuously is re-accepted on the first IDLE edge.
- S and Cout change only at tN or on reset; they are stable while busy.

## Test plan
- Reset, including mid-RUN: WIDTH=8, A=0xAA, B=0x55, start, then rst at t2 → busy=0, done=0, S=0x00, Cout=0 after the reset edge. No done pulse follows. The next start is accepted normally.
- Carry ripple across all digits: WIDTH=8, A=0xFF, B=0x01, Cin=0 → slice_Cin sequence 0,1,1,1. done after t4 with S=0x00, Cout=1.
- Carry-in only: WIDTH=8, A=0x00, B=0x00, Cin=1 → S=0x01, Cout=0. Then A=0xFF, B=0xFF, Cin=1 → S=0xFF, Cout=1.
- Exhaustive sweep: WIDTH=2 (N=1), all 32 combinations of A, B, Cin → {Cout,S}=A+B+Cin for each. done occurs 2 cycles after each accept.
- Handshake: WIDTH=8, pulse start again during RUN and during DONE → both ignored, and the result equals the first operands. Then hold start high → back-to-back accepts spaced 6 cycles apart.
- Random: WIDTH=16, 1000 random A/B/Cin → {Cout,S} matches the reference sum. S and Cout are unchanged while busy.
